// File: rtl/osd_trace_depacketization_if.sv
// DII flit link between the debug interconnect router port and a trace sink.
// The master drives the flit; the slave returns the accept (ready) signal.
interface osd_trace_depacketization_if;
  logic        valid;
  logic        last;
  logic [15:0] data;
  logic        ready;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/osd_trace_depacketization.sv
// Reassembles DII trace event packets (dest, src, header, payload words LSB first) into one event.
// Optional macro OSD_TRACE_DEPACK_STATS_EN adds a saturating drop_count output.
module osd_trace_depacketization #(
  parameter int         WIDTH             = 112,
  parameter logic [3:0] TYPE_SUB_OVERFLOW = 4'd5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           id,
  osd_trace_depacketization_if.slave debug_in,
  output logic [WIDTH-1:0]     event_data,
  output logic [15:0]          event_src,
  output logic                 event_overflow,
  output logic [15:0]          event_lost,
  output logic                 event_valid,
  input  logic                 event_ready
`ifdef OSD_TRACE_DEPACK_STATS_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int NW = (WIDTH + 15) / 16;
  localparam int PW = NW * 16;
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] NW_C      = CW'(NW);
  localparam logic [CW-1:0] NW_LAST_C = CW'(NW - 1);
  localparam logic [1:0]    TYPE_EVENT = 2'b10;

  typedef enum logic [2:0] {
    S_DEST    = 3'd0,
    S_SRC     = 3'd1,
    S_HDR     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [15:0]      src_reg, src_next;
  logic [15:0]      lost_reg, lost_next;
  logic             drop_inc;
  logic             accept;
  logic [PW-1:0]    pad_v;

  assign debug_in.ready = (state_reg != S_OUT);
  assign accept         = debug_in.valid && (state_reg != S_OUT);

  assign event_valid    = (state_reg == S_OUT);
  assign event_data     = data_reg;
  assign event_src      = src_reg;
  assign event_overflow = ovf_reg;
  assign event_lost     = lost_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_DEST;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      data_reg  <= '0;
      src_reg   <= '0;
      lost_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      data_reg  <= data_next;
      src_reg   <= src_next;
      lost_reg  <= lost_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    data_next  = data_reg;
    src_next   = src_reg;
    lost_next  = lost_reg;
    drop_inc   = 1'b0;
    pad_v      = '0;

    case (state_reg)
      S_DEST: begin
        if (accept) begin
          if (debug_in.last) begin
            drop_inc = 1'b1;
          end else if (debug_in.data[9:0] != id) begin
            state_next = S_DROP;
          end else begin
            state_next = S_SRC;
          end
        end
      end

      S_SRC: begin
        if (accept) begin
          src_next = debug_in.data;
          if (debug_in.last) begin
            state_next = S_DEST;
            drop_inc   = 1'b1;
          end else begin
            state_next = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (accept) begin
          cnt_next  = '0;
          data_next = '0;
          lost_next = '0;
          if (debug_in.data[15:14] != TYPE_EVENT) begin
            ovf_next = 1'b0;
            if (debug_in.last) begin
              state_next = S_DEST;
              drop_inc   = 1'b1;
            end else begin
              state_next = S_DROP;
            end
          end else begin
            ovf_next = (debug_in.data[13:10] == TYPE_SUB_OVERFLOW);
            if (debug_in.last) begin
              // A header-only overflow packet still reports, with zero lost count.
              if (debug_in.data[13:10] == TYPE_SUB_OVERFLOW) begin
                state_next = S_OUT;
              end else begin
                state_next = S_DEST;
                drop_inc   = 1'b1;
              end
            end else begin
              state_next = S_PAYLOAD;
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          if (cnt_reg != NW_C) begin
            cnt_next = cnt_reg + 1'b1;
          end
          if (ovf_reg) begin
            if (cnt_reg == '0) begin
              lost_next = debug_in.data;
            end
            if (debug_in.last) begin
              state_next = S_OUT;
            end
          end else begin
            // Slot the word into a padded copy so a partial top word truncates cleanly.
            pad_v[WIDTH-1:0] = data_reg;
            for (int k = 0; k < NW; k++) begin
              if (cnt_reg == CW'(k)) begin
                pad_v[k*16 +: 16] = debug_in.data;
              end
            end
            data_next = pad_v[WIDTH-1:0];
            if (debug_in.last) begin
              if (cnt_reg >= NW_LAST_C) begin
                state_next = S_OUT;
              end else begin
                state_next = S_DEST;
                drop_inc   = 1'b1;
              end
            end
          end
        end
      end

      S_DROP: begin
        if (accept && debug_in.last) begin
          state_next = S_DEST;
          drop_inc   = 1'b1;
        end
      end

      S_OUT: begin
        if (event_ready) begin
          state_next = S_DEST;
        end
      end

      default: begin
        state_next = S_DEST;
      end
    endcase
  end

`ifdef OSD_TRACE_DEPACK_STATS_EN
  logic [15:0] drop_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_reg <= '0;
    end else if (drop_inc && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign drop_count = drop_count_reg;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
`endif

endmodule

// File: tb/tb_osd_trace_depacketization.sv
// Directed bench for osd_trace_depacketization: expected events are queued when a packet
// is driven and compared when the consumer accepts them.
module tb_osd_trace_depacketization;
  localparam int WIDTH = 112;
  localparam int NW    = 7;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [15:0]      src;
    logic             ovf;
    logic [15:0]      lost;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [9:0]       id  = 10'h005;
  logic [WIDTH-1:0] event_data;
  logic [15:0]      event_src;
  logic             event_overflow;
  logic [15:0]      event_lost;
  logic             event_valid;
  logic             event_ready;
`ifdef OSD_TRACE_DEPACK_STATS_EN
  logic [15:0]      drop_count;
`endif

  osd_trace_depacketization_if bus();

  osd_trace_depacketization #(.WIDTH(WIDTH), .TYPE_SUB_OVERFLOW(4'd5)) dut (
    .clk            (clk),
    .rst            (rst),
    .id             (id),
    .debug_in       (bus),
    .event_data     (event_data),
    .event_src      (event_src),
    .event_overflow (event_overflow),
    .event_lost     (event_lost),
    .event_valid    (event_valid),
    .event_ready    (event_ready)
`ifdef OSD_TRACE_DEPACK_STATS_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  ev_t         exp_q[$];
  ev_t         mon_e;
  ev_t         hold_e;
  int          tests = 0;
  int          fails = 0;
  int          exp_drops = 0;
  logic [15:0] pl [0:15];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk_norm(input logic [15:0] src, input int n);
    ev_t e;
    e.data = '0;
    for (int k = 0; k < n && k < NW; k++) e.data[k*16 +: 16] = pl[k];
    e.src  = src;
    e.ovf  = 1'b0;
    e.lost = 16'h0000;
    return e;
  endfunction

  // Consumer side: one transaction line per accepted event.
  always @(negedge clk) begin
    if (!rst && event_valid === 1'b1 && event_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 128'd1, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] event src=%h ovf=%0d lost=%0d data=%h", event_src, event_overflow, event_lost, event_data);
        chk("ev_data", event_data, mon_e.data);
        chk("ev_src", event_src, mon_e.src);
        chk("ev_ovf", event_overflow, mon_e.ovf);
        chk("ev_lost", event_lost, mon_e.lost);
      end
    end
  end

  task automatic send_flit(input logic [15:0] d, input logic l);
    int n = 0;
    bus.valid = 1'b1;
    bus.data  = d;
    bus.last  = l;
    while (bus.ready !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("ready_timeout", 128'd0, 128'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
    bus.last  = 1'b0;
  endtask

  // Invalid cycles carry junk data and last=1; they must not affect parsing.
  task automatic idle(input int n);
    bus.valid = 1'b0;
    bus.last  = 1'b1;
    bus.data  = 16'hFFFF;
    repeat (n) begin @(posedge clk); #1; end
    bus.last  = 1'b0;
  endtask

  task automatic send_packet(input logic [15:0] dest, input logic [15:0] src,
                             input logic [15:0] hdr, input int n, input bit gap);
    send_flit(dest, 1'b0);
    send_flit(src, 1'b0);
    send_flit(hdr, n == 0);
    for (int k = 0; k < n; k++) begin
      if (gap && k == 2) idle(2);
      send_flit(pl[k], k == n - 1);
    end
    $display("[TB] packet dest=%h src=%h hdr=%h words=%0d", dest, src, hdr, n);
  endtask

  task automatic check_drops();
`ifdef OSD_TRACE_DEPACK_STATS_EN
    chk("drop_count", drop_count, exp_drops);
`endif
  endtask

  task automatic fill(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) pl[k] = base + 16'(k * 16'h0111);
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.last  = 1'b0;
    bus.data  = 16'h0000;
    event_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", event_valid, 0);
    chk("rst_data", event_data, 0);
    chk("rst_src", event_src, 0);
    chk("rst_ovf", event_overflow, 0);
    chk("rst_lost", event_lost, 0);
    chk("rst_ready", bus.ready, 1);
    check_drops();
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal event with an invalid-flit gap inside the payload.
    pl[0] = 16'h1234; pl[1] = 16'h2345; pl[2] = 16'h3456; pl[3] = 16'h4567;
    pl[4] = 16'h5678; pl[5] = 16'h6789; pl[6] = 16'hBEEF;
    exp_q.push_back(mk_norm(16'h0001, 7));
    send_packet(16'h0005, 16'h0001, 16'h8000, 7, 1'b1);
    chk("t1_latency_valid", event_valid, 1);
    chk("t1_ready_low", bus.ready, 0);
    chk("t1_low_word", event_data[15:0], 16'h1234);
    chk("t1_top_word", event_data[111:96], 16'hBEEF);
    idle(2);
    chk("t1_valid_cleared", event_valid, 0);

    // Overflow notification.
    pl[0] = 16'h0007;
    exp_q.push_back('{data: '0, src: 16'h0002, ovf: 1'b1, lost: 16'h0007});
    send_packet(16'h0005, 16'h0002, 16'h9400, 1, 1'b0);
    chk("t2_valid", event_valid, 1);
    idle(2);

    // Destination mismatch: ten flits swallowed, no event.
    fill(16'hA000, 7);
    send_packet(16'h0006, 16'h0003, 16'h8000, 7, 1'b0);
    chk("t3_no_event", event_valid, 0);
    chk("t3_ready", bus.ready, 1);
    exp_drops++;
    check_drops();
    idle(2);
    chk("t3_no_event_later", event_valid, 0);

    // Backpressure: event held for 20 cycles while the next packet waits.
    event_ready = 1'b0;
    fill(16'h1001, 7);
    hold_e = mk_norm(16'h0004, 7);
    exp_q.push_back(hold_e);
    send_packet(16'h0005, 16'h0004, 16'h8000, 7, 1'b0);
    bus.valid = 1'b1; bus.data = 16'h0005; bus.last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0 || c == 19) begin
        chk("bp_ready_low", bus.ready, 0);
        chk("bp_valid_held", event_valid, 1);
        chk("bp_data_held", event_data, hold_e.data);
        chk("bp_src_held", event_src, hold_e.src);
      end else if (bus.ready !== 1'b0 || event_data !== hold_e.data) begin
        chk("bp_stable", 128'd0, 128'd1);
      end
    end
    @(posedge clk); #1;
    event_ready = 1'b1;
    fill(16'h2002, 7);
    exp_q.push_back(mk_norm(16'h0005, 7));
    send_packet(16'h0005, 16'h0005, 16'h8000, 7, 1'b0);
    chk("bp_next_valid", event_valid, 1);
    idle(2);

    // Short normal packet dropped, then an over-long one truncated to NW words.
    fill(16'h3003, 3);
    send_packet(16'h0005, 16'h0006, 16'h8000, 3, 1'b0);
    chk("short_no_event", event_valid, 0);
    exp_drops++;
    check_drops();
    fill(16'h4004, 9);
    exp_q.push_back(mk_norm(16'h0007, 9));
    send_packet(16'h0005, 16'h0007, 16'h8000, 9, 1'b0);
    chk("long_valid", event_valid, 1);
    idle(2);

    // Wrong packet type is discarded.
    fill(16'h5005, 2);
    send_packet(16'h0005, 16'h000A, 16'h4000, 2, 1'b0);
    chk("type_no_event", event_valid, 0);
    exp_drops++;
    check_drops();

    // Asynchronous reset while word 3 of a payload is on the bus.
    fill(16'h6006, 4);
    send_flit(16'h0005, 1'b0);
    send_flit(16'h0008, 1'b0);
    send_flit(16'h8000, 1'b0);
    send_flit(pl[0], 1'b0);
    send_flit(pl[1], 1'b0);
    send_flit(pl[2], 1'b0);
    chk("pre_rst_src", event_src, 16'h0008);
    bus.valid = 1'b1; bus.data = pl[3]; bus.last = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", event_data, 0);
    chk("arst_src", event_src, 0);
    chk("arst_valid", event_valid, 0);
    chk("arst_ready", bus.ready, 1);
    exp_drops = 0;
    check_drops();
    #1;
    rst = 1'b0;
    bus.valid = 1'b0;
    @(posedge clk); #1;
    fill(16'h7007, 7);
    exp_q.push_back(mk_norm(16'h0009, 7));
    send_packet(16'h0005, 16'h0009, 16'h8000, 7, 1'b0);
    chk("post_rst_valid", event_valid, 1);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
